depp_stream_buffer: RTL
=======================

// Module: depp_stream_buffer
// PURPOSE
//  Sits directly between the DEPP emulated-UART port and user logic; owns that port's get/put handshakes.
//  Drains each PC->FPGA byte (byte_out, rtr=0) into an RX FIFO and fills the FPGA->PC register (byte_in) from a TX FIFO.
//  Presents both directions to user logic as valid/ready byte streams, so the PC never waits on user logic while FIFO space remains.
// PARAMETERS
//  DEPTH_LOG2   4   log2 of each FIFO depth (RX and TX both 2**DEPTH_LOG2 entries)
// PORTS
//  clk        in   1     system clock, all logic on posedge
//  rst        in   1     synchronous reset, active-high
//  byte_out   in   8     PC->FPGA byte from the DEPP port
//  rtr        in   1     0 = byte_out holds an unconsumed PC byte
//  get        out  1     request: PC byte consumed (4-phase with get_ack)
//  get_ack    in   1     acknowledge for get
//  byte_in    out  8     FPGA->PC byte to the DEPP port
//  rts        in   1     1 = previous FPGA->PC byte not yet read by PC
//  put        out  1     request: load byte_in (4-phase with put_ack)
//  put_ack    in   1     acknowledge for put
//  rx_data    out  8     head of RX FIFO
//  rx_valid   out  1     RX FIFO non-empty
//  rx_ready   in   1     user pops RX head when rx_valid & rx_ready
//  tx_data    in   8     byte to send to PC
//  tx_valid   in   1     user offers tx_data
//  tx_ready   out  1     TX FIFO not full; push when tx_valid & tx_ready
//  rx_count   out  DEPTH_LOG2+1  RX occupancy
//  tx_count   out  DEPTH_LOG2+1  TX occupancy
// BEHAVIOUR
//  Reset: get=0, put=0, byte_in=0, rx_valid=0, tx_ready=1, counts=0, both FSMs IDLE, FIFO contents discarded.
//  The DEPP port has no reset; its get_ack/put_ack may still be 1 after rst. FSMs must not issue a request until the ack reads 0.
//  RX FSM (R_IDLE, R_REQ, R_REL):
//   R_IDLE: if rtr==0 & get_ack==0 & RX not full -> push byte_out, get<=1, go R_REQ. If RX is full, stay (PC sees rtr=0 and waits).
//   R_REQ: hold get=1 until get_ack==1 -> get<=0, go R_REL.
//   R_REL: wait get_ack==0 -> R_IDLE. rtr is already 1 here, so no double capture.
//  TX FSM (T_IDLE, T_REQ, T_REL):
//   T_IDLE: if TX non-empty & rts==0 & put_ack==0 -> byte_in<=head, pop TX, put<=1, go T_REQ.
//   T_REQ: byte_in stays stable; on put_ack==1 -> put<=0, go T_REL.
//   T_REL: wait put_ack==0 -> T_IDLE. Gating on rts==0 guarantees no unread byte is overwritten.
//  FIFOs: synchronous, first-word-fall-through with registered flags.
//   A byte pushed at edge N gives rx_valid/rx_data at edge N+1; the same applies to tx_count.
//   Push and pop in the same cycle: count is unchanged and both pointers advance.
//   Full status uses the pre-edge count; push while full is ignored even if a pop occurs in the same cycle.
//   Pop while empty is ignored. Pointers wrap modulo 2**DEPTH_LOG2, and counts saturate at neither end.
//  Reset mid-handshake: get/put drop to 0 the following edge and FSMs return to IDLE.
//   The in-flight RX byte is lost; the PC sees rtr stay 0 and the byte is re-captured after reset.
//  Minimum full-rate cycle per byte is 4 clk per direction; RX and TX operate independently and concurrently.
// STRUCTURE
//  Shared package depp_pkg: FSM state localparams (R_IDLE/R_REQ/R_REL = 0/1/2, T_* likewise) and byte width 8.
//  Sub-module byte_fifo (params DEPTH_LOG2; ports clk, rst, wr_en, wr_data, rd_en, rd_data, empty, full, count).
//   It is instantiated twice (RX, TX); the top level holds only the two handshake FSMs and glue.
// TESTING
//  1. Bench models the DEPP port (rtr/rts/acks with 1-3 cycle ack delay).
//     PC writes 0xA5, then 0x3C, with rx_ready=1 -> rx_data yields 0xA5 then 0x3C; each transfer sees exactly one get pulse.
//  2. rx_ready=0, PC writes 17 bytes 0x00..0x10 with DEPTH_LOG2=4 -> rx_count=16 and rtr is still 0 for the 17th.
//     Raising rx_ready drains 0x00..0x0F, then 0x10 is captured.
//  3. User pushes 0x11, 0x22 and the PC model holds rts=1 for 20 cycles after the first -> byte_in=0x11 and put stays 0.
//     After rts falls, byte_in=0x22 and one put pulse is seen.
//  4. tx_valid=1 with the PC stalled until full -> tx_ready=0 at tx_count=16; the 17th tx_data is not accepted.
//     Later contents emerge in order with no loss.
//  5. Assert rst during R_REQ and T_REQ with get_ack/put_ack held 1 -> get=put=0 next edge.
//     No new request issues until the acks return to 0.
//  6. Simultaneous RX push and user pop at rx_count=16 -> push blocked and count becomes 15.
//     At count=8 with simultaneous push and pop -> count stays 8 and data order is preserved.

Source files
------------

// File: rtl/depp_pkg.sv
// Shared constants for the DEPP stream buffer: byte width and the
// encodings of the RX and TX handshake FSM states.
package depp_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_REQ  = 2'd1;
  localparam logic [1:0] R_REL  = 2'd2;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_REQ  = 2'd1;
  localparam logic [1:0] T_REL  = 2'd2;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with registered empty/full
// flags and an occupancy count; overflow and underflow requests are dropped.
module byte_fifo
  import depp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [BYTE_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [BYTE_W-1:0]     rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [BYTE_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DEPTH_LOG2:0]   next_count;

  // Flags are the pre-edge state, so a push while full is refused even
  // when a pop happens on the same edge.
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    next_count = count;
    case ({wr_ok, rd_ok})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: next_count = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= next_count;
      empty <= (next_count == '0);
      full  <= (next_count == FULL_CNT);
    end
  end

endmodule

// File: rtl/depp_stream_buffer.sv
// Buffers the DEPP emulated-UART port in both directions: PC bytes land in
// an RX FIFO, user bytes leave through a TX FIFO, each behind a 4-phase FSM.
module depp_stream_buffer
  import depp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_out,
  input  logic                 rtr,
  output logic                 get,
  input  logic                 get_ack,
  output logic [7:0]           byte_in,
  input  logic                 rts,
  output logic                 put,
  input  logic                 put_ack,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DEPTH_LOG2:0]  rx_count,
  output logic [DEPTH_LOG2:0]  tx_count
);

  // User streams: a byte moves on any edge where valid and ready are both 1;
  // valid never depends on ready, and data is stable while valid is held.

  logic [1:0]        r_state;
  logic [1:0]        t_state;
  logic              rx_push;
  logic              rx_empty;
  logic              rx_full;
  logic              tx_pop;
  logic              tx_empty;
  logic              tx_full;
  logic [BYTE_W-1:0] tx_head;

  assign rx_valid = ~rx_empty;
  assign tx_ready = ~tx_full;

  // The port's acks are not reset, so a stale ack must clear before a new request.
  assign rx_push = (r_state == R_IDLE) & ~rtr & ~get_ack & ~rx_full;
  assign tx_pop  = (t_state == T_IDLE) & ~tx_empty & ~rts & ~put_ack;

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_push),
    .wr_data (byte_out),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .empty   (rx_empty),
    .full    (rx_full),
    .count   (rx_count)
  );

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty),
    .full    (tx_full),
    .count   (tx_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      get     <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (rx_push) begin
          get     <= 1'b1;
          r_state <= R_REQ;
        end
        R_REQ: if (get_ack) begin
          get     <= 1'b0;
          r_state <= R_REL;
        end
        R_REL: if (!get_ack) r_state <= R_IDLE;
        default: begin
          get     <= 1'b0;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  // byte_in only changes on a pop, so it holds steady through T_REQ/T_REL.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_state <= T_IDLE;
      put     <= 1'b0;
      byte_in <= '0;
    end else begin
      case (t_state)
        T_IDLE: if (tx_pop) begin
          byte_in <= tx_head;
          put     <= 1'b1;
          t_state <= T_REQ;
        end
        T_REQ: if (put_ack) begin
          put     <= 1'b0;
          t_state <= T_REL;
        end
        T_REL: if (!put_ack) t_state <= T_IDLE;
        default: begin
          put     <= 1'b0;
          t_state <= T_IDLE;
        end
      endcase
    end
  end

endmodule
